// File: rtl/stream_pack_32to256_pkg.sv
// Shared types for the 32-to-256 stream packer.
// Holds the FSM state encoding used by the packer and its neighbours.
package stream_pack_32to256_pkg;

    typedef enum logic {
        FILL  = 1'b0,
        WRITE = 1'b1
    } pack_state_t;

    localparam int unsigned DEF_IN_WIDTH  = 32;
    localparam int unsigned DEF_OUT_WIDTH = 256;

endpackage

// File: rtl/stream_pack_32to256.sv
// Packs RATIO narrow valid/ready words (little-endian lanes) into one wide word
// and writes it through a FIFO we/din/full port; in_last or flush emits a padded partial word.
module stream_pack_32to256
    import stream_pack_32to256_pkg::*;
#(
    parameter int unsigned IN_WIDTH  = DEF_IN_WIDTH,
    parameter int unsigned OUT_WIDTH = DEF_OUT_WIDTH,
    parameter int unsigned PAD_VALUE = 0
) (
    input  logic                                      clk,
    input  logic                                      reset,
    input  logic                                      in_valid,
    input  logic [IN_WIDTH-1:0]                       in_data,
    input  logic                                      in_last,
    output logic                                      in_ready,
    input  logic                                      flush,
    output logic                                      fifo_we,
    output logic [OUT_WIDTH-1:0]                      fifo_din,
    input  logic                                      fifo_full,
    output logic [$clog2(OUT_WIDTH/IN_WIDTH):0]       lanes_used,
    output logic [31:0]                               words_out,
    output logic                                      busy
);

    localparam int unsigned RATIO     = OUT_WIDTH / IN_WIDTH;
    localparam int unsigned LANE_BITS = $clog2(RATIO);

    localparam logic [LANE_BITS-1:0] LANE_LAST = LANE_BITS'(RATIO - 1);
    localparam logic [IN_WIDTH-1:0]  PAD_LANE  = IN_WIDTH'(PAD_VALUE);
    localparam logic [OUT_WIDTH-1:0] PAD_FILL  = {RATIO{PAD_LANE}};

    pack_state_t            state, state_next;
    logic [LANE_BITS-1:0]   lane_idx;
    logic [OUT_WIDTH-1:0]   acc, acc_merged, hold;
    logic                   xfer, emit;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= FILL;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        in_ready   = (state == FILL);
        xfer       = in_valid && in_ready;
        acc_merged = acc;
        for (int unsigned k = 0; k < RATIO; k++) begin
            if (xfer && lane_idx == LANE_BITS'(k)) begin
                acc_merged[k*IN_WIDTH +: IN_WIDTH] = in_data;
            end
        end
        // A transfer always lands before the flush/last decision, so a coincident
        // flush behaves exactly like in_last on that word.
        emit = 1'b0;
        if (state == FILL) begin
            if (xfer) begin
                emit = (lane_idx == LANE_LAST) || in_last || flush;
            end else begin
                emit = flush && (lane_idx != '0);
            end
        end
        fifo_we    = (state == WRITE) && !fifo_full && !reset;
        state_next = state;
        case (state)
            FILL:    if (emit)    state_next = WRITE;
            WRITE:   if (fifo_we) state_next = FILL;
            default: state_next = FILL;
        endcase
    end

    // The accumulator is kept pre-filled with padding so an early emit needs no masking.
    always_ff @(posedge clk) begin
        if (reset) begin
            lane_idx   <= '0;
            acc        <= PAD_FILL;
            hold       <= '0;
            lanes_used <= '0;
            words_out  <= '0;
        end else begin
            if (emit) begin
                hold       <= acc_merged;
                lanes_used <= {1'b0, lane_idx} + {{LANE_BITS{1'b0}}, xfer};
                lane_idx   <= '0;
                acc        <= PAD_FILL;
            end else if (xfer) begin
                acc      <= acc_merged;
                lane_idx <= lane_idx + LANE_BITS'(1);
            end
            if (fifo_we) begin
                words_out <= words_out + 32'd1;
            end
        end
    end

    assign fifo_din = hold;
    assign busy     = (state == WRITE) || (lane_idx != '0);

endmodule

// File: tb/tb_stream_pack_32to256.sv
// Scoreboard bench for stream_pack_32to256: a lane model pushes expected wide
// words as stimulus is accepted; a negedge monitor pops and compares each FIFO write.
module tb_stream_pack_32to256;

    localparam int unsigned IW    = 32;
    localparam int unsigned OW    = 256;
    localparam int unsigned RATIO = OW / IW;

    typedef struct {
        logic [OW-1:0] data;
        logic [3:0]    lanes;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          in_valid = 1'b0;
    logic [IW-1:0] in_data = '0;
    logic          in_last = 1'b0;
    logic          flush = 1'b0;
    logic          in_ready, fifo_we, busy;
    logic [OW-1:0] fifo_din;
    logic [3:0]    lanes_used;
    logic [31:0]   words_out;
    logic          full_force = 1'b0;
    logic          rand_en = 1'b0;
    logic          rand_bit = 1'b0;
    logic          fifo_full;

    assign fifo_full = full_force | (rand_en & rand_bit);

    int            n_checks = 0;
    int            n_fail = 0;
    int            n_writes = 0;
    int            exp_words = 0;
    int            cyc = 0;
    exp_t          exp_q[$];
    logic [OW-1:0] m_acc = '0;
    int unsigned   m_idx = 0;

    stream_pack_32to256 #(
        .IN_WIDTH (IW),
        .OUT_WIDTH(OW),
        .PAD_VALUE(0)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .flush     (flush),
        .fifo_we   (fifo_we),
        .fifo_din  (fifo_din),
        .fifo_full (fifo_full),
        .lanes_used(lanes_used),
        .words_out (words_out),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc++;
        rand_bit <= ($urandom_range(0, 2) == 0);
    end

    task automatic check(input string tag, input logic [OW-1:0] obs, input logic [OW-1:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (fifo_we) begin
            n_writes++;
            check("write_pending", OW'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("sb_din", fifo_din, e.data);
                check("sb_lanes", OW'(lanes_used), OW'(e.lanes));
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic m_push(input int unsigned lanes);
        exp_t e;
        e.data  = m_acc;
        e.lanes = 4'(lanes);
        exp_q.push_back(e);
        exp_words++;
        m_acc = '0;
        m_idx = 0;
    endtask

    task automatic send(input logic [IW-1:0] d, input logic last = 1'b0, input logic fl = 1'b0);
        int waits = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        flush    = fl;
        while (!in_ready && waits < 300) begin
            tick(1);
            waits++;
        end
        if (!in_ready) begin
            check("send_timeout", OW'(in_ready), 1);
            in_valid = 1'b0;
            in_last  = 1'b0;
            flush    = 1'b0;
            return;
        end
        tick(1);
        in_valid = 1'b0;
        in_last  = 1'b0;
        flush    = 1'b0;
        m_acc[m_idx*IW +: IW] = d;
        m_idx++;
        if (m_idx == RATIO || last || fl) m_push(m_idx);
    endtask

    task automatic do_flush();
        logic rdy;
        rdy   = in_ready;
        flush = 1'b1;
        tick(1);
        flush = 1'b0;
        if (rdy && m_idx > 0) m_push(m_idx);
    endtask

    task automatic drain();
        int w = 0;
        while (exp_q.size() != 0 && w < 500) begin
            tick(1);
            w++;
        end
        tick(1);
        check("drain_empty", OW'(exp_q.size()), 0);
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_acc     = '0;
        m_idx     = 0;
        exp_words = 0;
    endtask

    initial begin : watchdog
        #3000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int c0;
        int w0;
        int len;

        // Reset state
        reset = 1'b1;
        tick(3);
        reset = 1'b0;
        #1;
        check("rst_we", OW'(fifo_we), 0);
        check("rst_din", fifo_din, 0);
        check("rst_lanes", OW'(lanes_used), 0);
        check("rst_words", OW'(words_out), 0);
        check("rst_busy", OW'(busy), 0);
        check("rst_ready", OW'(in_ready), 1);

        // 1. Basic pack: write lands in the ninth cycle
        c0 = cyc;
        for (int i = 0; i < 8; i++) send(IW'(i));
        check("t1_backtoback", OW'(cyc - c0), 8);
        check("t1_we_cycle9", OW'(fifo_we), 1);
        tick(1);
        check("t1_we_once", OW'(fifo_we), 0);
        check("t1_words", OW'(words_out), 1);

        // 2. Partial frame
        send(32'hA);
        send(32'hB);
        send(32'hC, 1'b1);
        drain();
        check("t2_words", OW'(words_out), OW'(exp_words));

        // 3. Backpressure with flush during the stall
        w0 = n_writes;
        full_force = 1'b1;
        for (int i = 0; i < 8; i++) send(IW'(32'h100 + i));
        for (int i = 0; i < 20; i++) begin
            if (i == 10) do_flush();
            else tick(1);
            check("t3_we_stall", OW'(fifo_we), 0);
            check("t3_ready_stall", OW'(in_ready), 0);
            if (exp_q.size() != 0) check("t3_din_stable", fifo_din, exp_q[0].data);
        end
        full_force = 1'b0;
        #1;
        check("t3_we_release", OW'(fifo_we), 1);
        drain();
        check("t3_one_write", OW'(n_writes - w0), 1);

        // 4. Flush cases
        w0 = n_writes;
        do_flush();
        tick(3);
        check("t4_empty_flush", OW'(n_writes - w0), 0);
        for (int i = 0; i < 5; i++) send(IW'(32'h200 + i));
        do_flush();
        drain();
        for (int i = 0; i < 4; i++) send(IW'(32'h200 + i));
        send(32'h204, 1'b0, 1'b1);
        drain();
        check("t4_two_writes", OW'(n_writes - w0), 2);
        check("t4_words", OW'(words_out), OW'(exp_words));

        // 5. Reset mid-op, then reset while a write is pending and FIFO just freed
        for (int i = 0; i < 4; i++) send(IW'(32'h300 + i));
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        model_reset();
        check("t5_busy_after_rst", OW'(busy), 0);
        full_force = 1'b1;
        for (int i = 0; i < 8; i++) send(IW'(32'h400 + i));
        reset = 1'b1;
        full_force = 1'b0;
        #1;
        check("t5_no_we_in_rst", OW'(fifo_we), 0);
        tick(1);
        reset = 1'b0;
        model_reset();
        check("t5_busy_after_rst2", OW'(busy), 0);
        check("t5_words_rst", OW'(words_out), 0);
        for (int i = 0; i < 8; i++) send(IW'(32'h10 + i));
        drain();
        check("t5_words", OW'(words_out), 1);

        // 6. Random frames with random backpressure
        rand_en = 1'b1;
        for (int f = 0; f < 1000; f++) begin
            len = $urandom_range(1, 12);
            for (int i = 0; i < len; i++) begin
                if ($urandom_range(0, 3) == 0) tick($urandom_range(1, 2));
                if ($urandom_range(0, 15) == 0) do_flush();
                send($urandom(), 1'(i == len - 1), 1'($urandom_range(0, 19) == 0));
            end
        end
        rand_en = 1'b0;
        drain();
        check("t6_words", OW'(words_out), OW'(exp_words));
        check("t6_idle", OW'(busy), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
